keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_ctrl_if.sv | 21 ++
 rtl/keypad_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad matrix lines and key-delivery handshake between the scan controller and its environment.
interface keypad_scan_ctrl_if;
   logic [3:0] fil;
   logic [3:0] col;
   logic [3:0] tecla;
   logic       tipo;
   logic       key_valid;
   logic       key_ack;
   logic       overrun;
   logic [3:0] pulsacion;

   modport master (
      input  fil, key_ack,
      output col, tecla, tipo, key_valid, overrun, pulsacion
   );

   modport slave (
      output fil, key_ack,
      input  col, tecla, tipo, key_valid, overrun, pulsacion
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Clocked 4x4 keypad scanner: one-hot column strobe, debounced single-key capture,
// (tecla, tipo) decode, valid/ack delivery and a wrap-around press counter.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   keypad_scan_ctrl_if.master bus
);
   localparam int DW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   state_t        r_state;
   logic [DW-1:0] r_div;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_cap;
   logic [3:0]    r_col;
   logic [3:0]    r_tecla;
   logic          r_tipo;
   logic          r_key_valid;
   logic          r_overrun;
   logic [3:0]    r_pulsacion;

   logic          w_sample;
   logic          w_onehot;
   logic          w_press;
   logic [CW-1:0] w_cnt_inc;
   logic [4:0]    w_code;

   function automatic logic f_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [3:0] f_rotate(input logic [3:0] c);
      return {c[0], c[3:1]};
   endfunction

   // Returns {tipo, tecla}; row bit3 is the top row, column bit3 the left column.
   function automatic logic [4:0] f_decode(input logic [3:0] c, input logic [3:0] r);
      logic [4:0] code;
      case ({c, r})
         8'b1000_1000: code = {1'b1, 4'd1};
         8'b1000_0100: code = {1'b1, 4'd4};
         8'b1000_0010: code = {1'b1, 4'd7};
         8'b1000_0001: code = {1'b0, 4'd10};
         8'b0100_1000: code = {1'b1, 4'd2};
         8'b0100_0100: code = {1'b1, 4'd5};
         8'b0100_0010: code = {1'b1, 4'd8};
         8'b0100_0001: code = {1'b1, 4'd0};
         8'b0010_1000: code = {1'b1, 4'd3};
         8'b0010_0100: code = {1'b1, 4'd6};
         8'b0010_0010: code = {1'b1, 4'd9};
         8'b0010_0001: code = {1'b0, 4'd6};
         8'b0001_1000: code = {1'b0, 4'd0};
         8'b0001_0100: code = {1'b0, 4'd1};
         8'b0001_0010: code = {1'b0, 4'd2};
         8'b0001_0001: code = {1'b0, 4'd3};
         default:      code = {1'b0, 4'd0};
      endcase
      return code;
   endfunction

   // Classify the row sample and decide whether this sample point completes a press.
   always_comb begin
      w_sample  = (r_div == DIV_LAST);
      w_onehot  = f_onehot(bus.fil);
      w_cnt_inc = r_cnt + CW'(1);
      w_code    = f_decode(r_col, bus.fil);
      w_press   = 1'b0;
      if (w_sample && (r_state == ST_SCAN)) begin
         w_press = w_onehot && (DEB_N == CW'(1));
      end else if (w_sample && (r_state == ST_DEBOUNCE)) begin
         w_press = (bus.fil == r_cap) && (w_cnt_inc == DEB_N);
      end else begin
         w_press = 1'b0;
      end
   end

   // Scan sequencer, debounce counters and registered key outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SCAN;
         r_div       <= {DW{1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_cap       <= 4'd0;
         r_col       <= 4'b1000;
         r_tecla     <= 4'd0;
         r_tipo      <= 1'b0;
         r_key_valid <= 1'b0;
         r_overrun   <= 1'b0;
         r_pulsacion <= 4'd0;
      end else begin
         r_div <= w_sample ? {DW{1'b0}} : (r_div + DW'(1));

         if (w_sample) begin
            case (r_state)
               ST_SCAN: begin
                  if (w_onehot) begin
                     r_cap   <= bus.fil;
                     r_cnt   <= CW'(1);
                     r_state <= ST_DEBOUNCE;
                  end else begin
                     r_col <= f_rotate(r_col);
                  end
               end
               ST_DEBOUNCE: begin
                  if (bus.fil == r_cap) begin
                     r_cnt <= w_cnt_inc;
                  end else begin
                     r_state <= ST_SCAN;
                     r_cnt   <= {CW{1'b0}};
                     r_col   <= f_rotate(r_col);
                  end
               end
               ST_HELD: begin
                  // Multi-hot rows still count as the key being held.
                  if (bus.fil != 4'd0) begin
                     r_cnt <= {CW{1'b0}};
                  end else if (w_cnt_inc == DEB_N) begin
                     r_state <= ST_SCAN;
                     r_cnt   <= {CW{1'b0}};
                     r_col   <= f_rotate(r_col);
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               default: begin
                  r_state <= ST_SCAN;
                  r_cnt   <= {CW{1'b0}};
               end
            endcase
         end

         // A press overrides the state update above and wins over a same-cycle ack.
         if (w_press) begin
            r_state     <= ST_HELD;
            r_cnt       <= {CW{1'b0}};
            r_tipo      <= w_code[4];
            r_tecla     <= w_code[3:0];
            r_key_valid <= 1'b1;
            r_pulsacion <= r_pulsacion + 4'd1;
            if (r_key_valid && !bus.key_ack) begin
               r_overrun <= 1'b1;
            end
         end else if (r_key_valid && bus.key_ack) begin
            r_key_valid <= 1'b0;
         end
      end
   end

   assign bus.col       = r_col;
   assign bus.tecla     = r_tecla;
   assign bus.tipo      = r_tipo;
   assign bus.key_valid = r_key_valid;
   assign bus.overrun   = r_overrun;
   assign bus.pulsacion = r_pulsacion;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: decode table vectors, directed corner sequences and
// randomized row activity checked every cycle against a behavioural keypad model.
module tb_keypad_scan_ctrl;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   keypad_scan_ctrl_if bus();

   keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] col;
      logic [3:0] row;
      logic [3:0] tecla;
      logic       tipo;
      logic [3:0] cnt;
   } vec_t;

   vec_t vec[16];
   int   tv[16] = '{1, 4, 7, 10, 2, 5, 8, 0, 3, 6, 9, 6, 0, 1, 2, 3};
   bit   tt[16] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
   logic [3:0] top = 4'b1000;

   // Behavioural model: column index, mode 0 scanning / 1 confirming / 2 waiting release.
   int   m_phase = 0;
   int   m_col_idx = 0;
   int   m_mode = 0;
   int   m_run = 0;
   int   m_cnt = 0;
   logic [3:0] m_cap = 4'd0;
   logic [3:0] m_tecla = 4'd0;
   logic m_tipo = 1'b0;
   logic m_valid = 1'b0;
   logic m_ovr = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic model_step();
      logic press;
      int   row_idx;
      press   = 1'b0;
      row_idx = 0;
      for (int i = 0; i < 4; i++) if (bus.fil[3-i]) row_idx = i;
      if (m_phase == SCAN_DIV - 1) begin
         if (m_mode == 0) begin
            if ($countones(bus.fil) == 1) begin
               m_cap = bus.fil;
               m_run = 1;
               if (m_run == DEBOUNCE) press = 1'b1;
               else m_mode = 1;
            end else begin
               m_col_idx = (m_col_idx + 1) % 4;
            end
         end else if (m_mode == 1) begin
            if (bus.fil == m_cap) begin
               m_run++;
               if (m_run == DEBOUNCE) press = 1'b1;
            end else begin
               m_mode = 0;
               m_col_idx = (m_col_idx + 1) % 4;
            end
         end else begin
            m_run = (bus.fil == 4'd0) ? m_run + 1 : 0;
            if (m_run == DEBOUNCE) begin
               m_mode = 0;
               m_run = 0;
               m_col_idx = (m_col_idx + 1) % 4;
            end
         end
      end
      if (press) begin
         m_mode  = 2;
         m_run   = 0;
         m_tecla = vec[m_col_idx * 4 + row_idx].tecla;
         m_tipo  = vec[m_col_idx * 4 + row_idx].tipo;
         if (m_valid && !bus.key_ack) m_ovr = 1'b1;
         m_valid = 1'b1;
         m_cnt   = (m_cnt + 1) % 16;
      end else if (m_valid && bus.key_ack) begin
         m_valid = 1'b0;
      end
      m_phase = (m_phase + 1) % SCAN_DIV;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0; m_col_idx = 0; m_mode = 0; m_run = 0; m_cnt = 0;
            m_cap = 4'd0; m_tecla = 4'd0; m_tipo = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
         end else begin
            model_step();
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("model_col", int'(bus.col), int'(top >> m_col_idx));
            check("model_tecla", int'(bus.tecla), int'(m_tecla));
            check("model_tipo", int'(bus.tipo), int'(m_tipo));
            check("model_valid", int'(bus.key_valid), int'(m_valid));
            check("model_overrun", int'(bus.overrun), int'(m_ovr));
            check("model_pulsacion", int'(bus.pulsacion), m_cnt);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog @%0t: got timeout expected finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.fil = 4'd0;
      bus.key_ack = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   // Returns at the negedge just after col switched to c.
   task automatic wait_col(input logic [3:0] c);
      for (int i = 0; i < 64 && bus.col == c; i++) step(1);
      for (int i = 0; i < 64 && bus.col != c; i++) step(1);
      check("col_reach", int'(bus.col), int'(c));
   endtask

   task automatic ack_pulse();
      bus.key_ack = 1'b1;
      step(1);
      bus.key_ack = 1'b0;
      check("ack_clears", int'(bus.key_valid), 0);
   endtask

   task automatic press_key(input logic [3:0] c, input logic [3:0] r);
      logic [3:0] p0;
      wait_col(c);
      p0 = bus.pulsacion;
      bus.fil = r;
      for (int i = 0; i < 40 && bus.pulsacion == p0; i++) step(1);
      check("press_seen", int'(bus.pulsacion != p0), 1);
      bus.fil = 4'd0;
      for (int i = 0; i < 40 && bus.col == c; i++) step(1);
      check("release_resume", int'(bus.col != c), 1);
   endtask

   initial begin
      int kind;
      int len;
      for (int i = 0; i < 16; i++) begin
         vec[i].col   = top >> (i / 4);
         vec[i].row   = top >> (i % 4);
         vec[i].tecla = 4'(tv[i]);
         vec[i].tipo  = tt[i];
         vec[i].cnt   = 4'((i + 1) % 16);
      end
      bus.fil = 4'd0;
      bus.key_ack = 1'b0;
      step(1);
      chk_en = 1'b1;
      do_reset();

      // Idle scan after reset.
      for (int k = 0; k < 20; k++) begin
         check("idle_col", int'(bus.col), int'(top >> ((k / 4) % 4)));
         step(1);
      end
      check("idle_valid", int'(bus.key_valid), 0);
      check("idle_pulsacion", int'(bus.pulsacion), 0);

      // Press latency on key 5, frozen column, resume after release.
      wait_col(4'b0100);
      bus.fil = 4'b0100;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         check("latency_valid", int'(bus.key_valid), (k == 12) ? 1 : 0);
      end
      check("key5_tecla", int'(bus.tecla), 5);
      check("key5_tipo", int'(bus.tipo), 1);
      check("key5_pulsacion", int'(bus.pulsacion), 1);
      step(8);
      check("held_col", int'(bus.col), 4'b0100);
      bus.fil = 4'd0;
      for (int i = 0; i < 20 && bus.col == 4'b0100; i++) step(1);
      check("resume_col", int'(bus.col), 4'b0010);
      check("single_press", int'(bus.pulsacion), 1);
      ack_pulse();

      // One-sample bounce is discarded, then a stable press of key 10.
      wait_col(4'b1000);
      bus.fil = 4'b0001;
      step(4);
      bus.fil = 4'd0;
      step(4);
      check("bounce_col", int'(bus.col), 4'b0100);
      check("bounce_valid", int'(bus.key_valid), 0);
      press_key(4'b1000, 4'b0001);
      check("key10_tecla", int'(bus.tecla), 10);
      check("key10_tipo", int'(bus.tipo), 0);
      ack_pulse();

      // Handshake and overrun.
      press_key(4'b0001, 4'b0001);
      check("key3_tecla", int'(bus.tecla), 3);
      check("key3_valid", int'(bus.key_valid), 1);
      ack_pulse();
      press_key(4'b0010, 4'b0010);
      check("key9_tecla", int'(bus.tecla), 9);
      check("key9_overrun", int'(bus.overrun), 0);
      press_key(4'b0100, 4'b1000);
      check("key2_tecla", int'(bus.tecla), 2);
      check("key2_overrun", int'(bus.overrun), 1);
      check("key2_valid", int'(bus.key_valid), 1);
      check("key2_pulsacion", int'(bus.pulsacion), 5);

      // Full decode table from reset; sixteenth press wraps the counter to 0.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         press_key(vec[i].col, vec[i].row);
         check("table_tecla", int'(bus.tecla), int'(vec[i].tecla));
         check("table_tipo", int'(bus.tipo), int'(vec[i].tipo));
         check("table_pulsacion", int'(bus.pulsacion), int'(vec[i].cnt));
         ack_pulse();
      end

      // Multi-hot rows never produce a key.
      bus.fil = 4'b1100;
      step(40);
      bus.fil = 4'd0;
      check("multihot_valid", int'(bus.key_valid), 0);
      check("multihot_pulsacion", int'(bus.pulsacion), 0);

      // Asynchronous reset while a key is held and pending.
      wait_col(4'b0100);
      bus.fil = 4'b0100;
      for (int i = 0; i < 20 && !bus.key_valid; i++) step(1);
      check("pre_reset_valid", int'(bus.key_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_col", int'(bus.col), 4'b1000);
      check("async_tecla", int'(bus.tecla), 0);
      check("async_tipo", int'(bus.tipo), 0);
      check("async_valid", int'(bus.key_valid), 0);
      check("async_overrun", int'(bus.overrun), 0);
      check("async_pulsacion", int'(bus.pulsacion), 0);
      @(negedge clk);
      bus.fil = 4'd0;
      rst_n = 1'b1;
      step(1);
      check("post_reset_col", int'(bus.col), 4'b1000);

      // Randomized row activity and acks, checked cycle by cycle against the model.
      for (int s = 0; s < 500; s++) begin
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 24);
         if (kind < 3) bus.fil = 4'd0;
         else if (kind < 8) bus.fil = top >> $urandom_range(0, 3);
         else bus.fil = 4'($urandom_range(0, 15));
         for (int c = 0; c < len; c++) begin
            bus.key_ack = ($urandom_range(0, 3) == 0);
            step(1);
         end
      end
      bus.key_ack = 1'b0;
      bus.fil = 4'd0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
